// File: rtl/fire_pkg.sv
// Shared definitions for the fire-module layer blocks: data width, word type
// and the OFM writer state encoding.
package fire_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : fire_pkg

// File: rtl/fire2_squeeze_ofm_writer.sv
// Captures the CH parallel squeeze-layer output words on each sample pulse and
// serialises them into the single-port OFM RAM, pixel-major / channel-minor.
module fire2_squeeze_ofm_writer
  import fire_pkg::*;
#(
  parameter int WOUT  = 64,
  parameter int CH    = 16,
  parameter int WIDTH = fire_pkg::WIDTH,
  parameter int AW    = $clog2(WOUT * WOUT * CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] ofm_i [0:CH-1],
  input  logic             layer_finish_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             ram_feedback_o,
  output logic             done_o,
  output logic             overflow_o
);

  localparam int PW = (WOUT * WOUT > 1) ? $clog2(WOUT * WOUT) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(WOUT * WOUT - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);

  state_e           r_state, w_state_nxt;
  logic [PW-1:0]    r_pix, w_pix_nxt;
  logic [CW-1:0]    r_ch, w_ch_nxt;
  logic [WIDTH-1:0] r_shadow [0:CH-1];

  logic             w_capture;
  logic             w_wr_en_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_done_nxt;
  logic             w_fb_nxt;
  logic             w_ovf_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_ch indexes the word currently presented on the registered write port;
  // the first word of a pixel comes straight from ofm_i so it lands at t+1.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix;
    w_ch_nxt    = r_ch;
    w_capture   = 1'b0;
    w_wr_en_nxt = 1'b0;
    w_addr_nxt  = wr_addr_o;
    w_data_nxt  = wr_data_o;
    w_done_nxt  = done_o;
    w_fb_nxt    = ram_feedback_o;
    w_ovf_nxt   = overflow_o;

    unique case (r_state)
      IDLE: begin
        if (sample_i) begin
          w_capture   = 1'b1;
          w_ch_nxt    = '0;
          w_state_nxt = WRITE;
          w_wr_en_nxt = 1'b1;
          w_addr_nxt  = AW'({r_pix, {CW{1'b0}}});
          w_data_nxt  = ofm_i[0];
        end
      end

      WRITE: begin
        if (sample_i) w_ovf_nxt = 1'b1;
        if (r_ch == CH_LAST) begin
          if (r_pix == PIX_LAST) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_pix_nxt   = r_pix + 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_ch_nxt    = r_ch + 1'b1;
          w_wr_en_nxt = 1'b1;
          w_addr_nxt  = AW'({r_pix, w_ch_nxt});
          w_data_nxt  = r_shadow[w_ch_nxt];
        end
      end

      DONE: begin
        if (sample_i)       w_ovf_nxt = 1'b1;
        if (layer_finish_i) w_fb_nxt  = 1'b1;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix          <= '0;
      r_ch           <= '0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      done_o         <= 1'b0;
      ram_feedback_o <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      r_pix          <= w_pix_nxt;
      r_ch           <= w_ch_nxt;
      wr_en_o        <= w_wr_en_nxt;
      wr_addr_o      <= w_addr_nxt;
      wr_data_o      <= w_data_nxt;
      done_o         <= w_done_nxt;
      ram_feedback_o <= w_fb_nxt;
      overflow_o     <= w_ovf_nxt;
    end
  end

  // NOTE: the shadow bank is a register file, not a RAM, so it is reset to a known zero state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) r_shadow[k] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < CH; k++) r_shadow[k] <= ofm_i[k];
    end
  end

endmodule : fire2_squeeze_ofm_writer
